// File: rtl/axi_txn_arbiter.sv
// axi_txn_arbiter: round-robin arbiter that feeds one shared transaction FIFO
// from NUM_REQ requesters, tags every entry with the requester id, drains the
// FIFO head to a single valid/ready consumer, and limits each requester to
// MAX_OUTSTANDING pushed-but-not-completed transactions.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_data_i   per-requester request and payload
//   req_ready_o              one-hot-or-zero accept
//   fifo_full_i/fifo_empty_i external FIFO status
//   fifo_push_o/fifo_data_o  push of {id, payload}
//   fifo_data_i/fifo_pop_o   FIFO head entry and pop
//   m_valid_o/m_ready_i      downstream handshake, m_id_o/m_data_o head fields
//   done_valid_i/done_id_i   completion strobe releasing one credit
//   err_o                    one-cycle pulse after an illegal completion
module axi_txn_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ID_WIDTH        = $clog2(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic                           fifo_full_i,
  input  logic                           fifo_empty_i,
  output logic                           fifo_push_o,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_data_o,
  input  logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_data_i,
  output logic                           fifo_pop_o,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [ID_WIDTH-1:0]            m_id_o,
  output logic [DATA_WIDTH-1:0]          m_data_o,
  input  logic                           done_valid_i,
  input  logic [ID_WIDTH-1:0]            done_id_i,
  output logic                           err_o
);

  localparam int unsigned          CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  logic [ID_WIDTH-1:0]   rr_q;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_REQ];
  logic                  err_q;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    credit_ret;
  logic                  done_illegal;

  logic                  hi_found;
  logic                  lo_found;
  logic [ID_WIDTH-1:0]   hi_id;
  logic [ID_WIDTH-1:0]   lo_id;
  logic                  grant_valid;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [DATA_WIDTH-1:0] grant_data;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid_i[i] && (cnt_q[i] < CNT_MAX);
    end
  end

  // Rotating priority as two ascending scans: indices at/above rr_q first,
  // then the ones below it. Only indices < NUM_REQ are ever visited, so the
  // wrap is modulo NUM_REQ regardless of ID_WIDTH.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (eligible[i]) begin
        if (ID_WIDTH'(i) >= rr_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_id    = ID_WIDTH'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_id    = ID_WIDTH'(i);
        end
      end
    end
    grant_valid = rst_ni && !fifo_full_i && (hi_found || lo_found);
    grant_id    = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    grant_data  = '0;
    req_ready_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        grant_data     = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready_o[i] = grant_valid;
      end
    end
  end

  // A completion is legal only for an in-range id holding at least one credit;
  // out-of-range ids match no counter and therefore fall into the error case.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      credit_ret[i] = done_valid_i && (done_id_i == ID_WIDTH'(i)) && (cnt_q[i] != '0);
    end
    done_illegal = done_valid_i && !(|credit_ret);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q  <= '0;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      err_q <= done_illegal;
      if (grant_valid) begin
        rr_q <= (grant_id == LAST_ID) ? '0 : grant_id + ID_WIDTH'(1);
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        case ({req_ready_o[i], credit_ret[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
          2'b01:   cnt_q[i] <= cnt_q[i] - CNT_WIDTH'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  assign fifo_push_o = grant_valid;
  assign fifo_data_o = {grant_id, grant_data};

  assign m_valid_o   = rst_ni && !fifo_empty_i;
  assign m_id_o      = fifo_data_i[ID_WIDTH+DATA_WIDTH-1 -: ID_WIDTH];
  assign m_data_o    = fifo_data_i[DATA_WIDTH-1:0];
  assign fifo_pop_o  = m_valid_o && m_ready_i;

  assign err_o       = err_q;

endmodule

// File: tb/tb_axi_txn_arbiter.sv
// Bench for axi_txn_arbiter: a 4-requester instance driven by directed and
// random stimulus against a transaction-level reference model, plus a
// 3-requester instance for pointer wrap. Each instance owns a depth-8 FIFO.
module tb_axi_txn_arbiter;
  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int MAXO  = 4;
  localparam int IW    = 2;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // 4-requester instance
  logic [N-1:0]     req_valid;
  logic [N*DW-1:0]  req_data;
  logic [N-1:0]     req_ready;
  logic             fifo_full  = 1'b0;
  logic             fifo_empty = 1'b1;
  logic             fifo_push, fifo_pop;
  logic [IW+DW-1:0] fifo_wdata;
  logic [IW+DW-1:0] fifo_rdata = '0;
  logic             m_valid, m_ready;
  logic [IW-1:0]    m_id;
  logic [DW-1:0]    m_data;
  logic             done_valid;
  logic [IW-1:0]    done_id;
  logic             err;

  // 3-requester instance
  logic [2:0]       r3_valid;
  logic [3*DW-1:0]  r3_data;
  logic [2:0]       r3_ready;
  logic             f3_full  = 1'b0;
  logic             f3_empty = 1'b1;
  logic             f3_push, f3_pop;
  logic [IW+DW-1:0] f3_wdata;
  logic [IW+DW-1:0] f3_rdata = '0;
  logic             m3_valid, m3_ready;
  logic [IW-1:0]    m3_id;
  logic [DW-1:0]    m3_data;
  logic             d3_valid;
  logic [IW-1:0]    d3_id;
  logic             err3;

  axi_txn_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty),
    .fifo_push_o(fifo_push), .fifo_data_o(fifo_wdata),
    .fifo_data_i(fifo_rdata), .fifo_pop_o(fifo_pop),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_id_o(m_id), .m_data_o(m_data),
    .done_valid_i(done_valid), .done_id_i(done_id), .err_o(err)
  );

  axi_txn_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(r3_valid), .req_data_i(r3_data), .req_ready_o(r3_ready),
    .fifo_full_i(f3_full), .fifo_empty_i(f3_empty),
    .fifo_push_o(f3_push), .fifo_data_o(f3_wdata),
    .fifo_data_i(f3_rdata), .fifo_pop_o(f3_pop),
    .m_valid_o(m3_valid), .m_ready_i(m3_ready), .m_id_o(m3_id), .m_data_o(m3_data),
    .done_valid_i(d3_valid), .done_id_i(d3_id), .err_o(err3)
  );

  // Non-fall-through FIFOs: push/pop sampled at the edge, head visible after.
  logic [IW+DW-1:0] fq[$];
  logic [IW+DW-1:0] fq3[$];
  logic             e_full, e3_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
    end else begin
      e_full = (fq.size() >= DEPTH);
      if (fifo_pop && fq.size() > 0) void'(fq.pop_front());
      if (fifo_push && !e_full) fq.push_back(fifo_wdata);
    end
    fifo_full  = (fq.size() >= DEPTH);
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() > 0) ? fq[0] : '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq3.delete();
    end else begin
      e3_full = (fq3.size() >= DEPTH);
      if (f3_pop && fq3.size() > 0) void'(fq3.pop_front());
      if (f3_push && !e3_full) fq3.push_back(f3_wdata);
    end
    f3_full  = (fq3.size() >= DEPTH);
    f3_empty = (fq3.size() == 0);
    f3_rdata = (fq3.size() > 0) ? fq3[0] : '0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: round-robin pointer, credits in use, expected err_o.
  int m_rr;
  int m_cnt [N];
  bit m_err_exp;

  task automatic m_reset();
    m_rr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_err_exp = 1'b0;
  endtask

  function automatic int m_winner();
    int k;
    if (fifo_full) return -1;
    for (int j = 0; j < N; j++) begin
      k = (m_rr + j) % N;
      if (req_valid[k] && m_cnt[k] < MAXO) return k;
    end
    return -1;
  endfunction

  task automatic m_advance();
    int w;
    int old_cnt [N];
    w = m_winner();
    old_cnt = m_cnt;
    if (w >= 0) begin
      m_cnt[w] = m_cnt[w] + 1;
      m_rr     = (w + 1) % N;
    end
    m_err_exp = 1'b0;
    if (done_valid) begin
      if (old_cnt[done_id] > 0) m_cnt[done_id] = m_cnt[done_id] - 1;
      else                      m_err_exp = 1'b1;
    end
  endtask

  task automatic cycle_end();
    m_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    req_valid = '0; req_data = '0; m_ready = 1'b0; done_valid = 1'b0; done_id = '0;
    r3_valid  = '0; r3_data  = '0; m3_ready = 1'b0; d3_valid = 1'b0; d3_id = '0;
  endtask

  task automatic apply_reset();
    set_idle();
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom();
    for (int i = 0; i < 3; i++) r3_data[i*DW +: DW] = $urandom();
  endtask

  task automatic test_reset();
    set_idle();
    #2;
    rst_n = 1'b0;
    req_valid = '1; m_ready = 1'b1; done_valid = 1'b1; done_id = 2'd1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000 || fifo_push !== 1'b0 || fifo_pop !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b push=%b pop=%b mvalid=%b, expected all 0",
               req_ready, fifo_push, fifo_pop, m_valid);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b, expected 0", err);
    end
    apply_reset();
  endtask

  task automatic test_fairness();
    logic [DW-1:0] last_data;
    logic [N-1:0]  exp_r;
    int k;
    apply_reset();
    req_valid = '1; m_ready = 1'b1;
    last_data = '0;
    for (int c = 0; c < 12; c++) begin
      k = c % N;
      exp_r = '0; exp_r[k] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== exp_r) begin
        n_fail++; $display("FAIL fair_grant c=%0d: got %b, expected %b", c, req_ready, exp_r);
      end
      n_checks++;
      if (fifo_push !== 1'b1 || fifo_wdata !== {k[IW-1:0], req_data[k*DW +: DW]}) begin
        n_fail++; $display("FAIL fair_push c=%0d: got %b/%h, expected 1/%h",
                           c, fifo_push, fifo_wdata, {k[IW-1:0], req_data[k*DW +: DW]});
      end
      n_checks++;
      if (c == 0) begin
        if (m_valid !== 1'b0) begin
          n_fail++; $display("FAIL fair_mvalid0: got %b, expected 0", m_valid);
        end
      end else if (m_valid !== 1'b1 || m_id !== IW'((c - 1) % N) || m_data !== last_data) begin
        n_fail++; $display("FAIL fair_drain c=%0d: got %b/%0d/%h, expected 1/%0d/%h",
                           c, m_valid, m_id, m_data, (c - 1) % N, last_data);
      end
      last_data = req_data[k*DW +: DW];
      cycle_end();
      req_data[k*DW +: DW] = $urandom();
    end
  endtask

  task automatic test_credit_limit();
    logic [N-1:0] exp_r;
    apply_reset();
    req_valid = 4'b0100; m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      exp_r = (c < MAXO) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      n_checks++;
      if (req_ready !== exp_r) begin
        n_fail++; $display("FAIL credit_fill c=%0d: got %b, expected %b", c, req_ready, exp_r);
      end
      cycle_end();
    end
    done_valid = 1'b1; done_id = 2'd2;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL credit_same_cycle: got %b, expected 0000", req_ready);
    end
    cycle_end();
    done_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      exp_r = (c == 0) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      n_checks++;
      if (req_ready !== exp_r || err !== 1'b0) begin
        n_fail++; $display("FAIL credit_release c=%0d: got %b err=%b, expected %b err=0",
                           c, req_ready, err, exp_r);
      end
      cycle_end();
    end
  endtask

  task automatic test_fifo_full();
    logic [N-1:0] exp_r;
    int k;
    apply_reset();
    req_valid = 4'b0011; m_ready = 1'b0;
    for (int c = 0; c < DEPTH; c++) begin
      k = c % 2;
      exp_r = '0; exp_r[k] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== exp_r || fifo_push !== 1'b1) begin
        n_fail++; $display("FAIL full_fill c=%0d: got %b/%b, expected %b/1", c, req_ready, fifo_push, exp_r);
      end
      cycle_end();
      req_data[k*DW +: DW] = $urandom();
    end
    // Free one credit on each side while full: the FIFO alone must block.
    for (int c = 0; c < 3; c++) begin
      done_valid = (c < 2); done_id = IW'(c);
      @(negedge clk);
      n_checks++;
      if (fifo_push !== 1'b0 || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL full_block c=%0d: got push=%b ready=%b, expected 0/0000",
                           c, fifo_push, req_ready);
      end
      cycle_end();
    end
    done_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fifo_pop !== 1'b1 || fifo_push !== 1'b0 || m_valid !== 1'b1) begin
      n_fail++; $display("FAIL full_poppush: got pop=%b push=%b mvalid=%b, expected 1/0/1",
                         fifo_pop, fifo_push, m_valid);
    end
    cycle_end();
    m_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_push !== 1'b1 || req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL full_resume: got push=%b ready=%b, expected 1/0001", fifo_push, req_ready);
    end
    cycle_end();
    @(negedge clk);
    n_checks++;
    if (fifo_push !== 1'b0) begin
      n_fail++; $display("FAIL full_again: got push=%b, expected 0", fifo_push);
    end
    cycle_end();
  endtask

  task automatic test_simul_done();
    logic [N-1:0] exp_r;
    apply_reset();
    req_valid = 4'b0010; m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0010) begin
        n_fail++; $display("FAIL simul_fill c=%0d: got %b, expected 0010", c, req_ready);
      end
      cycle_end();
    end
    done_valid = 1'b1; done_id = 2'd1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL simul_push_done: got %b, expected 0010", req_ready);
    end
    cycle_end();
    done_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      exp_r = (c == 0) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      n_checks++;
      if (req_ready !== exp_r) begin
        n_fail++; $display("FAIL simul_after c=%0d: got %b, expected %b", c, req_ready, exp_r);
      end
      cycle_end();
    end
    req_valid = 4'b0000; done_valid = 1'b1; done_id = 2'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (err !== (c == 1)) begin
        n_fail++; $display("FAIL illegal_err c=%0d: got %b, expected %b", c, err, (c == 1));
      end
      cycle_end();
      done_valid = 1'b0;
    end
    req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      exp_r = (c < MAXO) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      n_checks++;
      if (req_ready !== exp_r) begin
        n_fail++; $display("FAIL illegal_nochange c=%0d: got %b, expected %b", c, req_ready, exp_r);
      end
      cycle_end();
    end
  endtask

  task automatic test_wrap();
    int exp_id [4];
    logic [2:0] exp_r;
    exp_id[0] = 1; exp_id[1] = 2; exp_id[2] = 0; exp_id[3] = 2;
    apply_reset();
    r3_valid = 3'b010; m3_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (r3_ready !== 3'b010 || f3_wdata[IW+DW-1 -: IW] !== 2'd1) begin
      n_fail++; $display("FAIL wrap_setup: got %b id=%0d, expected 010 id=1", r3_ready, f3_wdata[IW+DW-1 -: IW]);
    end
    cycle_end();
    r3_valid = 3'b101;
    for (int c = 0; c < 4; c++) begin
      exp_r = (c % 2 == 0) ? 3'b100 : 3'b001;
      @(negedge clk);
      n_checks++;
      if (r3_ready !== exp_r) begin
        n_fail++; $display("FAIL wrap_grant c=%0d: got %b, expected %b", c, r3_ready, exp_r);
      end
      n_checks++;
      if (m3_valid !== 1'b1 || m3_id !== IW'(exp_id[c])) begin
        n_fail++; $display("FAIL wrap_mid c=%0d: got %b/%0d, expected 1/%0d", c, m3_valid, m3_id, exp_id[c]);
      end
      cycle_end();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_valid = 4'b1000; m_ready = 1'b0;
    for (int c = 0; c < MAXO; c++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b1000) begin
        n_fail++; $display("FAIL mid_fill c=%0d: got %b, expected 1000", c, req_ready);
      end
      cycle_end();
    end
    req_valid = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL mid_pre: got %b, expected 0010", req_ready);
    end
    cycle_end();
    req_valid = 4'b1110; m_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    n_checks++;
    if (req_ready !== 4'b0000 || fifo_push !== 1'b0 || fifo_pop !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_drop: got ready=%b push=%b pop=%b mvalid=%b, expected all 0",
                         req_ready, fifo_push, fifo_pop, m_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL mid_first_grant: got %b, expected 0010", req_ready);
    end
    cycle_end();
    req_valid = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL mid_credit_cleared: got %b, expected 1000", req_ready);
    end
    cycle_end();
  endtask

  task automatic test_random();
    int w;
    logic [N-1:0] exp_r;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = $urandom();
        end
      end
      m_ready    = ($urandom_range(99) < (((c / 100) % 2 == 1) ? 85 : 25));
      done_valid = ($urandom_range(2) == 0);
      done_id    = IW'($urandom_range(N - 1));
      @(negedge clk);
      w = m_winner();
      exp_r = '0;
      if (w >= 0) exp_r[w] = 1'b1;
      n_checks++;
      if (req_ready !== exp_r || fifo_push !== (w >= 0)) begin
        n_fail++; $display("FAIL rand_grant c=%0d: got %b/%b, expected %b/%b", c, req_ready, fifo_push, exp_r, (w >= 0));
      end
      if (w >= 0) begin
        n_checks++;
        if (fifo_wdata !== {IW'(w), req_data[w*DW +: DW]}) begin
          n_fail++; $display("FAIL rand_wdata c=%0d: got %h, expected %h", c, fifo_wdata, {IW'(w), req_data[w*DW +: DW]});
        end
      end
      n_checks++;
      if (m_valid !== (fq.size() > 0) || fifo_pop !== ((fq.size() > 0) && m_ready)) begin
        n_fail++; $display("FAIL rand_drain c=%0d: got mvalid=%b pop=%b, expected %b/%b",
                           c, m_valid, fifo_pop, (fq.size() > 0), ((fq.size() > 0) && m_ready));
      end
      if (fq.size() > 0) begin
        n_checks++;
        if ({m_id, m_data} !== fq[0]) begin
          n_fail++; $display("FAIL rand_head c=%0d: got %h, expected %h", c, {m_id, m_data}, fq[0]);
        end
      end
      n_checks++;
      if (err !== m_err_exp) begin
        n_fail++; $display("FAIL rand_err c=%0d: got %b, expected %b", c, err, m_err_exp);
      end
      cycle_end();
      if (w >= 0) req_valid[w] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fairness();
    test_credit_limit();
    test_fifo_full();
    test_simul_done();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
